// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS inter-stage pipeline registers.
// Holds the control-bundle layout, per-stage payload widths and the counter helper.
package pipe_pkg;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jmp_and_link;
    logic       mem_read;
    logic       mem_write;
    logic       branch_equal;
    logic       branch_not_equal;
    logic       alu_src;
    logic       byte_op;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_BUNDLE_W = $bits(ctrl_t);

  // Payload widths for each stage boundary of the five-stage core.
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_DATA_W  = 128;
  localparam int unsigned EX_MEM_DATA_W = 101;
  localparam int unsigned MEM_WB_DATA_W = 101;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_CLEAR = 2'd2
  } slot_op_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control bundle and payload.
// Clearing drops valid and zeroes control; the payload keeps its last loaded value.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_BUNDLE_W,
  parameter int unsigned DATA_W = ID_EX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  slot_op_e          op,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    case (op)
      SLOT_LOAD: begin
        valid_d = 1'b1;
        ctrl_d  = ld_ctrl;
        data_d  = ld_data;
      end
      SLOT_CLEAR: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with bubble insertion, flush,
// optional one-entry skid buffer and saturating stall/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = ID_EX_DATA_W,
  parameter int unsigned CTRL_W = CTRL_BUNDLE_W,
  parameter bit          SKID   = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  slot_op_e          main_op;
  slot_op_e          skid_op;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic [DATA_W-1:0] main_ld_data;

  logic accept;
  logic drain;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign accept = in_valid && in_ready;
  assign drain  = main_valid && out_ready;

  // One transfer decision covers both variants: with SKID=0 the skid slot is
  // tied empty and in_ready never allows an accept into a full, stalled main.
  always_comb begin
    main_op      = SLOT_HOLD;
    skid_op      = SLOT_HOLD;
    main_ld_ctrl = in_ctrl;
    main_ld_data = in_data;
    if (flush) begin
      main_op = SLOT_CLEAR;
      skid_op = SLOT_CLEAR;
    end else if (!main_valid || drain) begin
      if (skid_valid) begin
        main_op      = SLOT_LOAD;
        main_ld_ctrl = skid_ctrl;
        main_ld_data = skid_data;
        skid_op      = SLOT_CLEAR;
      end else if (accept) begin
        main_op = SLOT_LOAD;
      end else if (main_valid) begin
        main_op = SLOT_CLEAR;
      end
    end else if (accept) begin
      skid_op = SLOT_LOAD;
    end
  end

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .op      (main_op),
    .ld_ctrl (main_ld_ctrl),
    .ld_data (main_ld_data),
    .valid   (main_valid),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .op      (skid_op),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
      );
      assign in_ready = !skid_valid;
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = !main_valid || out_ready;
    end
  endgenerate

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid && !out_ready) begin
      stall_cnt_d = CNT_W'(sat_inc(32'(stall_cnt_q), 32'(CNT_MAX)));
    end
    if (flush && (main_valid || skid_valid)) begin
      flush_cnt_d = CNT_W'(sat_inc(32'(flush_cnt_q), 32'(CNT_MAX)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance (CNT_W=4) and one
// combinational-ready instance, each with an expected-output queue drained by a monitor.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 14;

  logic clk;

  logic          s_rst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [CW-1:0] s_in_ctrl, s_out_ctrl;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [3:0]    s_stall_cnt, s_flush_cnt;

  logic          c_rst, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [CW-1:0] c_in_ctrl, c_out_ctrl;
  logic [DW-1:0] c_in_data, c_out_data;
  logic [15:0]   c_stall_cnt, c_flush_cnt;

  logic [CW+DW-1:0] s_exp_q[$];
  logic [CW+DW-1:0] c_exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .SKID   (1'b1),
    .CNT_W  (4)
  ) u_skid (
    .clk       (clk),
    .rst       (s_rst),
    .flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_ctrl   (s_in_ctrl),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_ctrl  (s_out_ctrl),
    .out_data  (s_out_data),
    .stall_cnt (s_stall_cnt),
    .flush_cnt (s_flush_cnt)
  );

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .SKID   (1'b0),
    .CNT_W  (16)
  ) u_comb (
    .clk       (clk),
    .rst       (c_rst),
    .flush     (c_flush),
    .in_valid  (c_in_valid),
    .in_ready  (c_in_ready),
    .in_ctrl   (c_in_ctrl),
    .in_data   (c_in_data),
    .out_valid (c_out_valid),
    .out_ready (c_out_ready),
    .out_ctrl  (c_out_ctrl),
    .out_data  (c_out_data),
    .stall_cnt (c_stall_cnt),
    .flush_cnt (c_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input bit push);
    s_in_valid = v;
    s_in_ctrl  = c;
    s_in_data  = d;
    if (push) s_exp_q.push_back({c, d});
  endtask

  task automatic c_drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input bit push);
    c_in_valid = v;
    c_in_ctrl  = c;
    c_in_data  = d;
    if (push) c_exp_q.push_back({c, d});
  endtask

  always @(negedge clk) begin
    if (s_out_valid && s_out_ready) begin
      if (s_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL skid_unexpected_out: got 0x%0h expected no output", {s_out_ctrl, s_out_data});
      end else begin
        check("skid_out", 64'({s_out_ctrl, s_out_data}), 64'(s_exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (c_out_valid && c_out_ready) begin
      if (c_exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL comb_unexpected_out: got 0x%0h expected no output", {c_out_ctrl, c_out_data});
      end else begin
        check("comb_out", 64'({c_out_ctrl, c_out_data}), 64'(c_exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_rst = 1'b1; s_flush = 1'b0; s_out_ready = 1'b0;
    c_rst = 1'b1; c_flush = 1'b0; c_out_ready = 1'b0;
    s_drive(1'b0, '0, '0, 1'b0);
    c_drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    s_rst = 1'b0;
    c_rst = 1'b0;

    check("rst_out_valid", 64'(s_out_valid), 64'd0);
    check("rst_out_ctrl",  64'(s_out_ctrl),  64'd0);
    check("rst_out_data",  64'(s_out_data),  64'd0);
    check("rst_in_ready",  64'(s_in_ready),  64'd1);
    check("rst_stall_cnt", 64'(s_stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(s_flush_cnt), 64'd0);
    check("rst_comb_in_ready", 64'(c_in_ready), 64'd1);

    // Streaming through the skid variant
    s_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_drive(1'b1, CW'(i), DW'(i), 1'b1);
      check("stream_in_ready", 64'(s_in_ready), 64'd1);
      tick();
      check("stream_out_valid", 64'(s_out_valid), 64'd1);
      check("stream_out_data",  64'(s_out_data),  64'(i));
    end
    s_drive(1'b0, '0, '0, 1'b0);
    tick();
    check("stream_stall_cnt", 64'(s_stall_cnt), 64'd0);

    // Bubble in a stream with all-ones control on the idle input
    s_drive(1'b1, 14'h0005, 32'h10, 1'b1);
    tick();
    s_drive(1'b0, '1, 32'h11, 1'b0);
    tick();
    check("bubble_out_valid", 64'(s_out_valid), 64'd0);
    check("bubble_out_ctrl",  64'(s_out_ctrl),  64'd0);
    check("bubble_out_data",  64'(s_out_data),  64'h10);
    s_drive(1'b1, 14'h0003, 32'h12, 1'b1);
    tick();
    check("after_bubble_valid", 64'(s_out_valid), 64'd1);
    check("after_bubble_data",  64'(s_out_data),  64'h12);
    s_drive(1'b0, '0, '0, 1'b0);
    tick();

    // Stall with skid: A into main, B into skid
    s_out_ready = 1'b0;
    s_drive(1'b1, 14'h0001, 32'hA0, 1'b1);
    check("stall_a_in_ready", 64'(s_in_ready), 64'd1);
    tick();
    s_drive(1'b1, 14'h0002, 32'hB0, 1'b1);
    check("stall_b_in_ready", 64'(s_in_ready), 64'd1);
    tick();
    s_drive(1'b0, '0, '0, 1'b0);
    check("stall_full_in_ready", 64'(s_in_ready), 64'd0);
    check("stall_full_out_data", 64'(s_out_data), 64'hA0);
    check("stall_full_out_valid", 64'(s_out_valid), 64'd1);
    tick();
    s_out_ready = 1'b1;
    tick();
    check("skid_move_out_data", 64'(s_out_data), 64'hB0);
    check("skid_move_in_ready", 64'(s_in_ready), 64'd1);
    tick();
    check("stall_drained_valid", 64'(s_out_valid), 64'd0);
    check("stall_cnt_two", 64'(s_stall_cnt), 64'd2);

    // Flush with both slots full and C offered
    s_out_ready = 1'b0;
    s_drive(1'b1, 14'h02A5, 32'hC0, 1'b1);
    tick();
    s_drive(1'b1, 14'h015A, 32'hC1, 1'b1);
    tick();
    check("flush_full_in_ready", 64'(s_in_ready), 64'd0);
    s_flush = 1'b1;
    s_drive(1'b1, '1, 32'hCC, 1'b0);
    tick();
    s_flush = 1'b0;
    s_drive(1'b0, '0, '0, 1'b0);
    void'(s_exp_q.pop_back());
    void'(s_exp_q.pop_back());
    check("flush_out_valid", 64'(s_out_valid), 64'd0);
    check("flush_out_ctrl",  64'(s_out_ctrl),  64'd0);
    check("flush_out_data",  64'(s_out_data),  64'hC0);
    check("flush_in_ready",  64'(s_in_ready),  64'd1);
    check("flush_cnt_one",   64'(s_flush_cnt), 64'd1);
    check("flush_stall_cnt", 64'(s_stall_cnt), 64'd4);

    // Flush of an empty stage discards the same-cycle accept and is not counted
    s_flush = 1'b1;
    s_drive(1'b1, 14'h0011, 32'hDD, 1'b0);
    tick();
    s_flush = 1'b0;
    s_drive(1'b0, '0, '0, 1'b0);
    check("empty_flush_valid", 64'(s_out_valid), 64'd0);
    check("empty_flush_cnt",   64'(s_flush_cnt), 64'd1);
    s_out_ready = 1'b1;
    tick();
    tick();

    // Saturation of the 4-bit stall counter
    s_out_ready = 1'b0;
    s_drive(1'b1, 14'h0007, 32'hE0, 1'b1);
    tick();
    s_drive(1'b0, '0, '0, 1'b0);
    repeat (20) tick();
    check("stall_cnt_sat", 64'(s_stall_cnt), 64'd15);
    s_out_ready = 1'b1;
    tick();
    check("stall_cnt_sat_hold", 64'(s_stall_cnt), 64'd15);

    // Reset while both slots are full and stalled
    s_out_ready = 1'b0;
    s_drive(1'b1, 14'h0009, 32'hF0, 1'b1);
    tick();
    s_drive(1'b1, 14'h000A, 32'hF1, 1'b1);
    tick();
    s_drive(1'b0, '0, '0, 1'b0);
    check("pre_rst_in_ready", 64'(s_in_ready), 64'd0);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    void'(s_exp_q.pop_back());
    void'(s_exp_q.pop_back());
    check("midrst_out_valid", 64'(s_out_valid), 64'd0);
    check("midrst_in_ready",  64'(s_in_ready),  64'd1);
    check("midrst_stall_cnt", 64'(s_stall_cnt), 64'd0);
    check("midrst_flush_cnt", 64'(s_flush_cnt), 64'd0);
    check("midrst_out_ctrl",  64'(s_out_ctrl),  64'd0);
    check("midrst_out_data",  64'(s_out_data),  64'd0);
    s_out_ready = 1'b1;
    tick();

    // Streaming through the combinational-ready variant
    c_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      c_drive(1'b1, CW'(i), DW'(i), 1'b1);
      check("comb_stream_in_ready", 64'(c_in_ready), 64'd1);
      tick();
      check("comb_stream_out_data", 64'(c_out_data), 64'(i));
    end
    c_drive(1'b0, '0, '0, 1'b0);
    tick();
    check("comb_stream_stall_cnt", 64'(c_stall_cnt), 64'd0);

    // in_ready follows out_ready within the cycle when main is full
    c_out_ready = 1'b0;
    c_drive(1'b1, 14'h000B, 32'h200, 1'b1);
    tick();
    c_drive(1'b0, '0, '0, 1'b0);
    check("comb_full_in_ready", 64'(c_in_ready), 64'd0);
    c_out_ready = 1'b1;
    #1;
    check("comb_ready_follow", 64'(c_in_ready), 64'd1);
    c_drive(1'b1, 14'h000C, 32'h201, 1'b1);
    tick();
    c_drive(1'b0, '0, '0, 1'b0);
    check("comb_replace_data", 64'(c_out_data), 64'h201);
    tick();
    check("comb_drained_valid", 64'(c_out_valid), 64'd0);
    check("comb_stall_cnt", 64'(c_stall_cnt), 64'd0);
    check("comb_flush_cnt", 64'(c_flush_cnt), 64'd0);

    tick();
    check("skid_queue_empty", 64'(s_exp_q.size()), 64'd0);
    check("comb_queue_empty", 64'(c_exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
